// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: two-channel round-robin scheduler in front of the IP transmit
// send port. Grants one requester at a time, forwards its payload bytes with a
// one-cycle register delay, waits for the IP layer's final-byte pulse and then
// enforces a guard gap before the next grant. The IP layer cannot stall, so
// no byte is ever held back once a channel owns the datapath.
module ip_tx_arbiter #(
  parameter int P_GAP_CYCLES    = 12,   // idle cycles after i_ip_done (1..255)
  parameter int P_START_TIMEOUT = 255   // max wait for first byte (1..65535)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // channel 0 (UDP)
  input  logic        i_c0_req,
  input  logic [7:0]  i_c0_type,
  input  logic [15:0] i_c0_len,
  output logic        o_c0_grant,
  input  logic [7:0]  i_c0_data,
  input  logic        i_c0_valid,
  input  logic        i_c0_last,
  // channel 1 (ICMP)
  input  logic        i_c1_req,
  input  logic [7:0]  i_c1_type,
  input  logic [15:0] i_c1_len,
  output logic        o_c1_grant,
  input  logic [7:0]  i_c1_data,
  input  logic        i_c1_valid,
  input  logic        i_c1_last,
  // IP layer send port
  output logic [7:0]  o_send_type,
  output logic [15:0] o_send_len,
  output logic [7:0]  o_send_data,
  output logic        o_send_valid,
  output logic        o_send_last,
  input  logic        i_ip_done,
  // status
  output logic        o_busy,
  output logic        o_owner,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_PASS      = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_GAP       = 2'd3;

  localparam logic [7:0]  GAP_LAST   = 8'(P_GAP_CYCLES - 1);
  localparam logic [15:0] START_LAST = 16'(P_START_TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  gap_cnt;
  logic [15:0] start_cnt;
  logic        byte_seen;

  logic        pick_any;
  logic        pick_ch;
  logic [7:0]  sel_data;
  logic        sel_valid;
  logic        sel_last;

  // Arbitration pick and mux of the owning channel's byte stream.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick_any  = i_c0_req | i_c1_req;
    pick_ch   = (i_c0_req & i_c1_req) ? ~o_owner : i_c1_req;
    sel_data  = 8'h00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    // Only the channel holding the grant may reach the send port; the other
    // channel's strobes are dropped here.
    if (o_owner) begin
      sel_data  = i_c1_data;
      sel_valid = i_c1_valid & o_c1_grant;
      sel_last  = i_c1_last;
    end else begin
      sel_data  = i_c0_data;
      sel_valid = i_c0_valid & o_c0_grant;
      sel_last  = i_c0_last;
    end
  end

  assign o_busy = (state != S_IDLE);

  // Scheduler FSM, counters and registered send port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      gap_cnt      <= 8'd0;
      start_cnt    <= 16'd0;
      byte_seen    <= 1'b0;
      o_c0_grant   <= 1'b0;
      o_c1_grant   <= 1'b0;
      o_send_type  <= 8'd0;
      o_send_len   <= 16'd0;
      o_send_data  <= 8'd0;
      o_send_valid <= 1'b0;
      o_send_last  <= 1'b0;
      o_owner      <= 1'b1;  // ch0 wins the first contention
      o_timeout    <= 1'b0;
    end else begin
      // NOTE: all state updates here are non-blocking so every register sees pre-edge values.
      o_timeout    <= 1'b0;
      o_send_valid <= 1'b0;
      o_send_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            o_owner     <= pick_ch;
            o_c0_grant  <= ~pick_ch;
            o_c1_grant  <= pick_ch;
            o_send_type <= pick_ch ? i_c1_type : i_c0_type;
            o_send_len  <= pick_ch ? i_c1_len  : i_c0_len;
            start_cnt   <= 16'd0;
            byte_seen   <= 1'b0;
            state       <= S_PASS;
          end
        end
        S_PASS: begin
          o_send_data  <= sel_data;
          o_send_valid <= sel_valid;
          o_send_last  <= sel_valid & sel_last;
          if (sel_valid && sel_last) begin
            o_c0_grant <= 1'b0;
            o_c1_grant <= 1'b0;
            state      <= S_WAIT_DONE;
          end else if (!byte_seen && !sel_valid && start_cnt == START_LAST) begin
            // Requester never started: withdraw the grant and skip WAIT_DONE,
            // since the IP layer will never report a final byte.
            o_c0_grant <= 1'b0;
            o_c1_grant <= 1'b0;
            o_timeout  <= 1'b1;
            gap_cnt    <= 8'd0;
            state      <= S_GAP;
          end else if (sel_valid) begin
            byte_seen <= 1'b1;
          end else if (!byte_seen) begin
            start_cnt <= start_cnt + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (i_ip_done) begin
            gap_cnt <= 8'd0;
            state   <= S_GAP;
          end
        end
        default: begin  // S_GAP
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ip_tx_arbiter.md
# ip_tx_arbiter

Two-channel round-robin scheduler that shares the single IP transmit datapath between the UDP and ICMP transmit engines. It sits directly upstream of the IP transmit layer's send port. A requester must be granted before it streams. The block forwards exactly one frame at a time. It holds off the next grant until the IP layer reports the frame's last MAC byte, then waits a guard gap, because the IP layer has no backpressure.

## Interface
- P_GAP_CYCLES, 12, idle cycles inserted after i_ip_done before the next grant (1..255)
- P_START_TIMEOUT, 255, cycles a granted requester may wait before its first valid byte (1..65535)
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_cN_req  in  1  channel N (N=0 UDP, N=1 ICMP) frame request, level, held until grant
- i_cN_type  in  8  channel N IP protocol number, sampled on grant cycle
- i_cN_len  in  16  channel N payload length in bytes, sampled on grant cycle
- o_cN_grant  out  1  channel N owns the datapath; high from grant until its last byte is accepted
- i_cN_data  in  8  channel N payload byte
- i_cN_valid  in  1  channel N byte strobe; honoured only while o_cN_grant
- i_cN_last  in  1  channel N final byte, qualified by i_cN_valid
- o_send_type  out  8  to IP layer, latched type
- o_send_len  out  16  to IP layer, latched payload length
- o_send_data  out  8  to IP layer, payload byte
- o_send_valid  out  1  to IP layer, byte strobe
- o_send_last  out  1  to IP layer, final byte
- i_ip_done  in  1  one-cycle pulse from IP layer on its final MAC byte
- o_busy  out  1  high in every state except IDLE
- o_owner  out  1  channel of the current or most recent grant
- o_timeout  out  1  one-cycle pulse when a grant is withdrawn on start timeout

## Operation
- States: IDLE, PASS, WAIT_DONE, GAP.
- IDLE
  - If exactly one req is high, grant that channel.
  - If both are high, grant the channel that is not o_owner (round-robin).
  - Grant sets o_cN_grant, latches type/len into o_send_type/o_send_len, updates o_owner, and moves to PASS.
- PASS
  - Each cycle, forwards the granted channel's data/valid/last to o_send_* with a 1-cycle register delay.
  - The ungranted channel's valid/last are ignored and never appear on o_send_*.
  - On the accepted byte with i_cN_last=1, deassert o_cN_grant on the next edge and go to WAIT_DONE.
  - Start timer counts from the grant cycle while no valid byte has been seen. At count P_START_TIMEOUT-1 with no byte:
    - drop the grant;
    - pulse o_timeout;
    - go to GAP, skipping WAIT_DONE.
  - The timer stops at the first valid byte.
- WAIT_DONE
  - Wait for i_ip_done, then go to GAP.
  - i_ip_done in any other state is ignored.
- GAP
  - Counter runs 0..P_GAP_CYCLES-1, then the block returns to IDLE.
  - Requests seen during GAP are not granted until IDLE.
- Arithmetic and widths
  - Gap counter: 8 bits. Start timer: 16 bits.
  - Counters clear on every state entry.
  - Length is passed through unmodified; no check of byte count against len.
- Boundary cases
  - Valid and last on the first byte (1-byte frame): PASS then WAIT_DONE on the next edge.
  - req dropped after grant: the grant is kept; the frame proceeds or times out.
  - req stays high after last: the requester is eligible again after GAP; round-robin still favours the other channel if it requests.
- Reset mid-frame
  - All outputs go to reset values immediately; state goes to IDLE.
  - The partial frame is not completed; downstream recovery is the IP layer's concern.

## Timing
- Reset values: o_cN_grant=0, o_send_type=0, o_send_len=0, o_send_data=0, o_send_valid=0, o_send_last=0, o_busy=0, o_owner=1 (so ch0 wins the first contention), o_timeout=0.
- Grant latency: req high in IDLE at edge k gives o_cN_grant high after edge k+1.
- Data latency: input byte at edge j appears on o_send_* after edge j+1; valid gaps are preserved.
- o_send_type/len are stable from the grant through the end of WAIT_DONE.
- Minimum spacing from i_ip_done to the next grant: P_GAP_CYCLES+1 cycles.

## Test plan
- Single ch0 request, type 0x11, len 8, 8 contiguous bytes:
  - grant one cycle after req;
  - 8 bytes out with last on byte 8 and type 0x11/len 8 held;
  - i_ip_done 28 cycles later leads to IDLE 12 cycles after done.
- Both req high from reset: ch0 granted first. With both still requesting, ch1 (type 0x01, len 4) is granted next, then ch0.
- ch1 streams while ch0 toggles valid with random data: o_send_data matches ch1 bytes only; no ch0 byte leaks.
- Granted ch0 never sends valid with P_START_TIMEOUT=16:
  - grant drops after 16 cycles;
  - o_timeout pulses once;
  - GAP, then ch1 is granted.
- 1-byte frame (valid+last together): o_send_last on the same output byte; grant drops the next cycle.
- Assert i_rst in PASS after 3 bytes: all outputs go to reset values immediately; a new req after release is granted normally.
